// File: rtl/permutation_sequencer_if.sv
// permutation_sequencer_if: start/mode request and round-control strobes of the Ascon permutation sequencer.
// abort_i exists only when ASCON_SEQ_ABORT_EN is defined.
interface permutation_sequencer_if;
    logic       start_i;
    logic       mode_i;
    logic [3:0] round_o;
    logic       en_reg_state_o;
    logic       init_o;
    logic       busy_o;
    logic       done_o;
`ifdef ASCON_SEQ_ABORT_EN
    logic       abort_i;
    modport slave (input start_i, mode_i, abort_i, output round_o, en_reg_state_o, init_o, busy_o, done_o);
    modport master (output start_i, mode_i, abort_i, input round_o, en_reg_state_o, init_o, busy_o, done_o);
`else
    modport slave (input start_i, mode_i, output round_o, en_reg_state_o, init_o, busy_o, done_o);
    modport master (output start_i, mode_i, input round_o, en_reg_state_o, init_o, busy_o, done_o);
`endif
endinterface

// File: rtl/permutation_sequencer.sv
// permutation_sequencer: IDLE/RUN/DONE control FSM issuing Ascon p^a / p^b round indices.
// Optional abort of a running permutation is enabled by defining ASCON_SEQ_ABORT_EN.
module permutation_sequencer #(
    parameter int ROUND_LAST = 11,
    parameter int PB_START   = 6
) (
    input logic                    clock_i,
    input logic                    resetb_i,
    permutation_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] LAST = 4'(ROUND_LAST);
    localparam logic [3:0] PBS  = 4'(PB_START);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       init_q, init_d;
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
        end
    end
    // A counter beyond LAST in RUN can only come from an upset; it ends the run like the last round.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    cnt_d   = bus.mode_i ? PBS : 4'd0;
                    init_d  = 1'b1;
                end
            end
            RUN: begin
`ifdef ASCON_SEQ_ABORT_EN
                if (bus.abort_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else
`endif
                if (cnt_q >= LAST) state_d = DONE;
                else cnt_d = cnt_q + 4'd1;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end
    assign bus.round_o        = (state_q == RUN) ? cnt_q : 4'd0;
    assign bus.en_reg_state_o = (state_q == RUN);
    assign bus.busy_o         = (state_q == RUN);
    assign bus.init_o         = (state_q == RUN) && init_q;
    assign bus.done_o         = (state_q == DONE);
endmodule

// File: tb/tb_permutation_sequencer.sv
// tb_permutation_sequencer: scoreboard bench; a cycle-level model of accepted runs queues the expected
// per-cycle outputs and a monitor compares every cycle (empty queue means idle, all outputs 0).
module tb_permutation_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    permutation_sequencer_if bus ();
    permutation_sequencer dut (.clock_i(clk), .resetb_i(rst_n), .bus(bus.slave));
    logic [7:0] exp_q[$];
    int rem = 0;
    int vectors = 0;
    int errs = 0;
    bit found;
    // one entry per cycle: {round, init, en, busy, done}
    function automatic void push_run(logic m);
        int s = m ? 6 : 0;
        for (int r = s; r <= 11; r++) exp_q.push_back({4'(r), (r == s), 3'b110});
        exp_q.push_back(8'b0000_0001);
        rem = 12 - s + 1;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            rem = 0;
        end else if (rem > 0) begin
`ifdef ASCON_SEQ_ABORT_EN
            if (bus.abort_i && rem >= 2) begin
                exp_q.delete();
                rem = 0;
            end else
`endif
            rem--;
        end else if (bus.start_i) push_run(bus.mode_i);
    end
    always @(negedge clk) begin : monitor
        logic [7:0] act, exp;
        act = {bus.round_o, bus.init_o, bus.en_reg_state_o, bus.busy_o, bus.done_o};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL cycle_out t=%0t: got round=%0d init=%b en=%b busy=%b done=%b, expected round=%0d init=%b en=%b busy=%b done=%b",
                     $time, act[7:4], act[3], act[2], act[1], act[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    end
    initial begin
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
`ifdef ASCON_SEQ_ABORT_EN
        bus.abort_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b1; bus.mode_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (16) @(negedge clk);
        bus.start_i = 1'b1; bus.mode_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.start_i = 1'b1;
        repeat (60) begin
            bus.mode_i = 1'($urandom);
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        repeat (16) @(negedge clk);
        repeat (400) begin
            bus.start_i = ($urandom_range(0, 3) == 0);
            bus.mode_i  = 1'($urandom);
`ifdef ASCON_SEQ_ABORT_EN
            bus.abort_i = ($urandom_range(0, 15) == 0);
`endif
            @(negedge clk);
        end
        bus.start_i = 1'b0;
`ifdef ASCON_SEQ_ABORT_EN
        bus.abort_i = 1'b0;
        repeat (16) @(negedge clk);
        bus.start_i = 1'b1; bus.mode_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.busy_o && bus.round_o == 4'd11) found = 1;
            else @(negedge clk);
        end
        vectors++;
        if (!found) begin
            errs++;
            $display("FAIL abort_wait: round 11 not seen, expected within 20 cycles");
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.start_i = 1'b1; bus.mode_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
`endif
        repeat (16) @(negedge clk);
        bus.start_i = 1'b1; bus.mode_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.busy_o && bus.round_o == 4'd5) found = 1;
            else @(negedge clk);
        end
        vectors++;
        if (!found) begin
            errs++;
            $display("FAIL reset_wait: round 5 not seen, expected within 20 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.round_o, bus.init_o, bus.en_reg_state_o, bus.busy_o, bus.done_o} !== 8'h00) begin
            errs++;
            $display("FAIL async_reset: got round=%0d init=%b en=%b busy=%b done=%b, expected all 0",
                     bus.round_o, bus.init_o, bus.en_reg_state_o, bus.busy_o, bus.done_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        bus.start_i = 1'b1; bus.mode_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (12) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
